// File: rtl/btn_debouncer.sv
// Button/switch conditioner: multi-flop synchroniser followed by a stability-qualifying FSM.
// Emits a clean registered level plus single-cycle rise/fall strobes.
module btn_debouncer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    localparam int unsigned CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_in;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_d, rise_d, fall_d;

    // Input synchroniser; only the last stage is observed by the FSM.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE_LOW;
            cnt_q     <= '0;
            btn_level <= 1'b0;
            btn_rise  <= 1'b0;
            btn_fall  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            btn_level <= level_d;
            btn_rise  <= rise_d;
            btn_fall  <= fall_d;
        end
    end

    // Next-state logic: any reversal during a WAIT state aborts with no partial credit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = btn_level;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (sync_in) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync_in) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!sync_in) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (sync_in) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    assign busy = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

endmodule

// File: tb/tb_btn_debouncer.sv
// Scoreboard bench for btn_debouncer: stimulus queues expected strobes, monitors pop and compare.
module tb_btn_debouncer;

    typedef struct {
        logic        is_rise;
        int unsigned cyc;
    } ev_t;

    logic clk;
    logic rstn, btn_raw;
    logic btn_level, btn_rise, btn_fall, busy;
    logic rstn6, btn_raw6;
    logic level6, rise6, fall6, busy6;

    int unsigned cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    ev_t exp_q[$];
    ev_t exp6_q[$];
    logic prev_strobe = 1'b0;
    logic prev_strobe6 = 1'b0;

    btn_debouncer u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .busy      (busy)
    );

    btn_debouncer #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(2)) u_dut6 (
        .clk       (clk),
        .rstn      (rstn6),
        .btn_raw   (btn_raw6),
        .btn_level (level6),
        .btn_rise  (rise6),
        .btn_fall  (fall6),
        .busy      (busy6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor for the default-parameter instance.
    always @(negedge clk) begin
        ev_t e;
        if (btn_rise || btn_fall) begin
            check("strobe_overlap", 32'(btn_rise & btn_fall), 0);
            check("strobe_repeat", 32'(prev_strobe), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'({btn_rise, btn_fall}), 0);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", 32'(btn_rise), 32'(e.is_rise));
                check("strobe_cycle", cyc, e.cyc);
                check("level_at_strobe", 32'(btn_level), 32'(e.is_rise));
            end
        end
        prev_strobe = btn_rise | btn_fall;
    end

    // Monitor for the SYNC_STAGES=3 / DEBOUNCE_CYCLES=2 instance.
    always @(negedge clk) begin
        ev_t e;
        if (rise6 || fall6) begin
            check("p6_strobe_repeat", 32'(prev_strobe6), 0);
            if (exp6_q.size() == 0) begin
                check("p6_unexpected_strobe", 32'({rise6, fall6}), 0);
            end else begin
                e = exp6_q.pop_front();
                check("p6_strobe_kind", 32'(rise6), 32'(e.is_rise));
                check("p6_strobe_cycle", cyc, e.cyc);
                check("p6_level_at_strobe", 32'(level6), 32'(e.is_rise));
            end
        end
        prev_strobe6 = rise6 | fall6;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a clean level change and check the busy window around it.
    task automatic clean_edge(input logic val, input string name);
        int unsigned n;
        @(negedge clk);
        n = cyc;
        btn_raw = val;
        exp_q.push_back('{val, n + 6});
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check(name, 32'(busy), 32'((k >= 3) && (k <= 5)));
        end
    endtask

    initial begin
        int unsigned n;
        rstn     = 1'b0;
        btn_raw  = 1'b0;
        rstn6    = 1'b0;
        btn_raw6 = 1'b1;
        tick(3);
        check("rst_level", 32'(btn_level), 0);
        check("rst_rise", 32'(btn_rise), 0);
        check("rst_fall", 32'(btn_fall), 0);
        check("rst_busy", 32'(busy), 0);
        check("p6_rst_level", 32'(level6), 0);
        check("p6_rst_busy", 32'(busy6), 0);

        // Release both resets; the second instance sees its input high from the first edge.
        n = cyc;
        rstn  = 1'b1;
        rstn6 = 1'b1;
        exp6_q.push_back('{1'b1, n + 5});
        tick(4);

        // Clean press then hold.
        clean_edge(1'b1, "press_busy");
        tick(12);
        check("press_level", 32'(btn_level), 1);
        check("p6_level_held", 32'(level6), 1);

        // Clean release.
        clean_edge(1'b0, "release_busy");
        tick(6);
        check("release_level", 32'(btn_level), 0);

        // Glitch of DEBOUNCE_CYCLES-1 samples must be rejected.
        @(negedge clk);
        btn_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 3) btn_raw = 1'b0;
            check("glitch_busy", 32'(busy), 32'((k >= 3) && (k <= 5)));
        end
        check("glitch_level", 32'(btn_level), 0);

        // Bounce 1,0,1,1,0,1 then hold high: single rise after the last restart.
        @(negedge clk);
        n = cyc;
        btn_raw = 1'b1;
        exp_q.push_back('{1'b1, n + 11});
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            btn_raw = (k == 1 || k == 4) ? 1'b0 : 1'b1;
        end
        tick(6);
        check("bounce_level", 32'(btn_level), 1);
        check("bounce_busy_idle", 32'(busy), 0);

        // Back to low before the reset test.
        clean_edge(1'b0, "release2_busy");
        tick(4);
        check("release2_level", 32'(btn_level), 0);

        // Reset in the middle of WAIT_HIGH discards the qualification.
        @(negedge clk);
        btn_raw = 1'b1;
        tick(3);
        check("midrst_busy_before", 32'(busy), 1);
        rstn = 1'b0;
        tick(1);
        check("midrst_level", 32'(btn_level), 0);
        check("midrst_rise", 32'(btn_rise), 0);
        check("midrst_busy", 32'(busy), 0);
        tick(2);
        check("midrst_busy_held", 32'(busy), 0);

        // Input still high at release: a fresh rise after the standard latency.
        n = cyc;
        rstn = 1'b1;
        exp_q.push_back('{1'b1, n + 6});
        tick(10);
        check("rel_high_level", 32'(btn_level), 1);

        for (int k = 0; k < 50 && (exp_q.size() != 0 || exp6_q.size() != 0); k++) tick(1);
        check("exp_q_drained", exp_q.size(), 0);
        check("exp6_q_drained", exp6_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
